// File: rtl/weight_route_sched.sv
// Sequencer for the sequential weight router: walks a list of kernels stored
// back-to-back in weight SRAM, clearing, loading and streaming each one for a set number of passes.
module weight_route_sched #(
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [ADDR_WIDTH-1:0] i_kernel_words,
    input  logic [ADDR_WIDTH-1:0] i_route_size,
    input  logic [CNT_WIDTH-1:0]  i_num_kernels,
    input  logic [CNT_WIDTH-1:0]  i_reuse_count,
    input  logic                  i_consumer_ready,
    input  logic                  i_route_ready,
    input  logic                  i_route_done,
    output logic                  o_reg_clear,
    output logic                  o_fifo_clear,
    output logic                  o_route_en,
    output logic                  o_data_out_en,
    output logic                  o_route_reuse,
    output logic [ADDR_WIDTH-1:0] o_start_addr,
    output logic [ADDR_WIDTH-1:0] o_addr_offset,
    output logic [ADDR_WIDTH-1:0] o_route_size,
    output logic [CNT_WIDTH-1:0]  o_kernel_idx,
    output logic [CNT_WIDTH-1:0]  o_pass_idx,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_CLEAR     = 4'd1;
    localparam logic [3:0] S_LOAD      = 4'd2;
    localparam logic [3:0] S_WAIT_CONS = 4'd3;
    localparam logic [3:0] S_STREAM    = 4'd4;
    localparam logic [3:0] S_REUSE     = 4'd5;
    localparam logic [3:0] S_NEXT      = 4'd6;
    localparam logic [3:0] S_DONE      = 4'd7;
    localparam logic [3:0] S_ABORT     = 4'd8;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ZERO = CNT_WIDTH'(0);
    localparam logic [CNT_WIDTH:0]    CNT_ONE  = (CNT_WIDTH+1)'(1);

    logic [3:0]            state_q,        state_d;
    logic [ADDR_WIDTH-1:0] kernel_words_q, kernel_words_d;
    logic [CNT_WIDTH-1:0]  num_kernels_q,  num_kernels_d;
    logic [CNT_WIDTH-1:0]  reuse_count_q,  reuse_count_d;
    logic [ADDR_WIDTH-1:0] start_addr_q,   start_addr_d;
    logic [ADDR_WIDTH-1:0] addr_offset_q,  addr_offset_d;
    logic [ADDR_WIDTH-1:0] route_size_q,   route_size_d;
    logic [CNT_WIDTH-1:0]  kernel_idx_q,   kernel_idx_d;
    logic [CNT_WIDTH-1:0]  pass_idx_q,     pass_idx_d;

    logic reg_clear_q,   reg_clear_d;
    logic fifo_clear_q,  fifo_clear_d;
    logic route_en_q,    route_en_d;
    logic data_out_en_q, data_out_en_d;
    logic route_reuse_q, route_reuse_d;
    logic busy_q,        busy_d;
    logic done_q,        done_d;

    logic             abort_s;
    logic [CNT_WIDTH:0] pass_inc_s;
    logic [CNT_WIDTH:0] kernel_inc_s;

    // Widened increments so the last-pass / last-kernel compares cannot overflow.
    assign pass_inc_s   = {1'b0, pass_idx_q} + CNT_ONE;
    assign kernel_inc_s = {1'b0, kernel_idx_q} + CNT_ONE;
    assign abort_s      = i_abort && (state_q != S_IDLE) && (state_q != S_ABORT);

    // Next-state and datapath register update; abort overrides every other event.
    always_comb begin
        state_d        = state_q;
        kernel_words_d = kernel_words_q;
        num_kernels_d  = num_kernels_q;
        reuse_count_d  = reuse_count_q;
        start_addr_d   = start_addr_q;
        addr_offset_d  = addr_offset_q;
        route_size_d   = route_size_q;
        kernel_idx_d   = kernel_idx_q;
        pass_idx_d     = pass_idx_q;

        if (abort_s) begin
            state_d      = S_ABORT;
            kernel_idx_d = CNT_ZERO;
            pass_idx_d   = CNT_ZERO;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        kernel_words_d = i_kernel_words;
                        num_kernels_d  = i_num_kernels;
                        reuse_count_d  = i_reuse_count;
                        start_addr_d   = i_base_addr;
                        addr_offset_d  = i_kernel_words - ADDR_ONE;
                        route_size_d   = i_route_size;
                        kernel_idx_d   = CNT_ZERO;
                        pass_idx_d     = CNT_ZERO;
                        if ((i_num_kernels == CNT_ZERO) || (i_reuse_count == CNT_ZERO)) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_CLEAR;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_CLEAR: state_d = S_LOAD;
                S_LOAD: begin
                    if (i_route_ready) begin
                        state_d = S_WAIT_CONS;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
                S_WAIT_CONS: begin
                    if (i_consumer_ready) begin
                        state_d = S_STREAM;
                    end else begin
                        state_d = S_WAIT_CONS;
                    end
                end
                S_STREAM: begin
                    if (i_route_done) begin
                        if (pass_inc_s < {1'b0, reuse_count_q}) begin
                            pass_idx_d = pass_inc_s[CNT_WIDTH-1:0];
                            state_d    = S_REUSE;
                        end else begin
                            state_d = S_NEXT;
                        end
                    end else begin
                        state_d = S_STREAM;
                    end
                end
                S_REUSE: state_d = S_WAIT_CONS;
                S_NEXT: begin
                    pass_idx_d = CNT_ZERO;
                    if (kernel_inc_s == {1'b0, num_kernels_q}) begin
                        state_d = S_DONE;
                    end else begin
                        kernel_idx_d = kernel_inc_s[CNT_WIDTH-1:0];
                        start_addr_d = start_addr_q + kernel_words_q;
                        state_d      = S_CLEAR;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                S_ABORT: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Control outputs decoded from the upcoming state so they register in step with it.
    always_comb begin
        reg_clear_d   = (state_d == S_CLEAR) || (state_d == S_ABORT);
        fifo_clear_d  = (state_d == S_CLEAR) || (state_d == S_ABORT);
        route_en_d    = (state_d == S_LOAD);
        data_out_en_d = (state_d == S_STREAM);
        route_reuse_d = (state_d == S_REUSE);
        busy_d        = (state_d != S_IDLE);
        done_d        = (state_d == S_DONE);
    end

    // State, latched configuration and registered outputs.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q        <= S_IDLE;
            kernel_words_q <= '0;
            num_kernels_q  <= '0;
            reuse_count_q  <= '0;
            start_addr_q   <= '0;
            addr_offset_q  <= '0;
            route_size_q   <= '0;
            kernel_idx_q   <= '0;
            pass_idx_q     <= '0;
            reg_clear_q    <= 1'b0;
            fifo_clear_q   <= 1'b0;
            route_en_q     <= 1'b0;
            data_out_en_q  <= 1'b0;
            route_reuse_q  <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            kernel_words_q <= kernel_words_d;
            num_kernels_q  <= num_kernels_d;
            reuse_count_q  <= reuse_count_d;
            start_addr_q   <= start_addr_d;
            addr_offset_q  <= addr_offset_d;
            route_size_q   <= route_size_d;
            kernel_idx_q   <= kernel_idx_d;
            pass_idx_q     <= pass_idx_d;
            reg_clear_q    <= reg_clear_d;
            fifo_clear_q   <= fifo_clear_d;
            route_en_q     <= route_en_d;
            data_out_en_q  <= data_out_en_d;
            route_reuse_q  <= route_reuse_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign o_reg_clear   = reg_clear_q;
    assign o_fifo_clear  = fifo_clear_q;
    assign o_route_en    = route_en_q;
    assign o_data_out_en = data_out_en_q;
    assign o_route_reuse = route_reuse_q;
    assign o_start_addr  = start_addr_q;
    assign o_addr_offset = addr_offset_q;
    assign o_route_size  = route_size_q;
    assign o_kernel_idx  = kernel_idx_q;
    assign o_pass_idx    = pass_idx_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;

endmodule

// File: tb/tb_weight_route_sched.sv
// Directed bench for weight_route_sched with a small router responder and
// event counters; expected values are hand-computed per scenario.
module tb_weight_route_sched;

    logic       i_clk = 1'b0;
    logic       i_nrst;
    logic       i_start, i_abort, i_consumer_ready;
    logic [7:0] i_base_addr, i_kernel_words, i_route_size;
    logic [7:0] i_num_kernels, i_reuse_count;
    logic       route_ready_s, route_done_s, done_force;
    logic       o_reg_clear, o_fifo_clear, o_route_en, o_data_out_en, o_route_reuse;
    logic [7:0] o_start_addr, o_addr_offset, o_route_size, o_kernel_idx, o_pass_idx;
    logic       o_busy, o_done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 i_clk = ~i_clk;

    weight_route_sched #(.ADDR_WIDTH(8), .CNT_WIDTH(8)) dut (
        .i_clk(i_clk), .i_nrst(i_nrst), .i_start(i_start), .i_abort(i_abort),
        .i_base_addr(i_base_addr), .i_kernel_words(i_kernel_words),
        .i_route_size(i_route_size), .i_num_kernels(i_num_kernels),
        .i_reuse_count(i_reuse_count), .i_consumer_ready(i_consumer_ready),
        .i_route_ready(route_ready_s), .i_route_done(route_done_s),
        .o_reg_clear(o_reg_clear), .o_fifo_clear(o_fifo_clear), .o_route_en(o_route_en),
        .o_data_out_en(o_data_out_en), .o_route_reuse(o_route_reuse),
        .o_start_addr(o_start_addr), .o_addr_offset(o_addr_offset),
        .o_route_size(o_route_size), .o_kernel_idx(o_kernel_idx),
        .o_pass_idx(o_pass_idx), .o_busy(o_busy), .o_done(o_done)
    );

    // Router responder: ready after 3 LOAD cycles, done after 4 STREAM cycles.
    int ld_cnt = 0;
    int st_cnt = 0;
    always @(posedge i_clk) begin
        ld_cnt <= o_route_en ? ld_cnt + 1 : 0;
        st_cnt <= o_data_out_en ? st_cnt + 1 : 0;
    end
    assign route_ready_s = o_route_en && (ld_cnt >= 2);
    assign route_done_s  = (o_data_out_en && (st_cnt >= 3)) || done_force;

    // Event counters; start address logged on every clear pulse.
    int n_clear = 0, n_reuse = 0, n_stream = 0, n_rdone = 0, n_done = 0, n_ctrl = 0;
    logic       prev_doe = 1'b0;
    logic [7:0] addr_log [64];
    always @(posedge i_clk) begin
        if (o_reg_clear) begin
            addr_log[n_clear % 64] <= o_start_addr;
            n_clear <= n_clear + 1;
        end
        if (o_route_reuse) n_reuse <= n_reuse + 1;
        if (o_data_out_en && !prev_doe) n_stream <= n_stream + 1;
        prev_doe <= o_data_out_en;
        if (o_data_out_en && route_done_s) n_rdone <= n_rdone + 1;
        if (o_done) n_done <= n_done + 1;
        if (o_reg_clear || o_fifo_clear || o_route_en || o_data_out_en || o_route_reuse)
            n_ctrl <= n_ctrl + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge i_clk);
    endtask

    task automatic start_run(input logic [7:0] base, input logic [7:0] kw, input logic [7:0] rs,
                             input logic [7:0] nk, input logic [7:0] reuse);
        i_base_addr    = base;
        i_kernel_words = kw;
        i_route_size   = rs;
        i_num_kernels  = nk;
        i_reuse_count  = reuse;
        i_start        = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 2000 && !o_done; i++) tick();
        check({tag, "_done_seen"}, o_done, 1);
    endtask

    int c0, r0, s0, rd0, d0, k0;

    initial begin
        i_nrst = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_consumer_ready = 1'b1;
        done_force = 1'b0;
        i_base_addr = 8'h00; i_kernel_words = 8'h00; i_route_size = 8'h00;
        i_num_kernels = 8'h00; i_reuse_count = 8'h00;
        repeat (3) tick();
        check("rst_busy", o_busy, 0);
        check("rst_ctrl", {o_reg_clear, o_fifo_clear, o_route_en, o_data_out_en, o_route_reuse, o_done}, 0);
        check("rst_addr", {o_start_addr, o_addr_offset, o_route_size}, 0);
        check("rst_idx", {o_kernel_idx, o_pass_idx}, 0);
        i_nrst = 1'b1;
        tick();

        // Normal run: 2 kernels x 3 passes
        c0 = n_clear; r0 = n_reuse; s0 = n_stream; rd0 = n_rdone; d0 = n_done;
        start_run(8'h10, 8'h02, 8'h09, 8'h02, 8'h03);
        check("norm_clear_c1", {o_reg_clear, o_fifo_clear}, 2'b11);
        check("norm_start_addr", o_start_addr, 8'h10);
        check("norm_offset", o_addr_offset, 8'h01);
        check("norm_route_size", o_route_size, 8'h09);
        tick();
        check("norm_route_en_c2", o_route_en, 1);
        wait_done("norm");
        tick();
        check("norm_busy_after", o_busy, 0);
        check("norm_clears", n_clear - c0, 2);
        check("norm_reuses", n_reuse - r0, 4);
        check("norm_streams", n_stream - s0, 6);
        check("norm_rdone", n_rdone - rd0, 6);
        check("norm_done_once", n_done - d0, 1);
        check("norm_addr_k0", addr_log[c0 % 64], 8'h10);
        check("norm_addr_k1", addr_log[(c0 + 1) % 64], 8'h12);

        // Degenerate configs
        k0 = n_ctrl; d0 = n_done;
        start_run(8'h10, 8'h02, 8'h09, 8'h00, 8'h03);
        check("degen_nk_done_c1", o_done, 1);
        tick();
        check("degen_nk_idle", {o_busy, o_done}, 0);
        start_run(8'h10, 8'h02, 8'h09, 8'h02, 8'h00);
        check("degen_reuse_done_c1", o_done, 1);
        tick();
        check("degen_no_ctrl", n_ctrl - k0, 0);
        check("degen_done_cnt", n_done - d0, 2);

        // Consumer stall after LOAD
        i_consumer_ready = 1'b0;
        start_run(8'h30, 8'h01, 8'h04, 8'h01, 8'h01);
        for (int i = 0; i < 50 && !o_route_en; i++) tick();
        check("stall_load_seen", o_route_en, 1);
        for (int i = 0; i < 50 && o_route_en; i++) tick();
        check("stall_load_left", o_route_en, 0);
        k0 = 0;
        for (int i = 0; i < 20; i++) begin
            if (o_data_out_en) k0++;
            tick();
        end
        check("stall_doe_low", k0, 0);
        i_consumer_ready = 1'b1;
        tick();
        check("stall_stream_next", o_data_out_en, 1);
        wait_done("stall");
        tick();

        // Abort in STREAM at kernel 1 pass 1, then clean restart
        d0 = n_done;
        start_run(8'h10, 8'h02, 8'h09, 8'h02, 8'h03);
        for (int i = 0; i < 500 && !(o_data_out_en && o_kernel_idx == 8'd1 && o_pass_idx == 8'd1); i++) tick();
        check("abort_reach_k1p1", {o_data_out_en, o_kernel_idx, o_pass_idx}, {1'b1, 8'd1, 8'd1});
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        check("abort_clear", {o_reg_clear, o_fifo_clear}, 2'b11);
        check("abort_idx", {o_kernel_idx, o_pass_idx}, 0);
        tick();
        check("abort_idle", {o_busy, o_reg_clear, o_fifo_clear}, 0);
        repeat (3) tick();
        check("abort_no_done", n_done - d0, 0);
        c0 = n_clear;
        start_run(8'h40, 8'h01, 8'h03, 8'h01, 8'h01);
        check("restart_k0", o_kernel_idx, 0);
        check("restart_addr", o_start_addr, 8'h40);
        wait_done("restart");
        tick();
        check("restart_one_clear", n_clear - c0, 1);

        // Address wrap
        c0 = n_clear;
        start_run(8'hFE, 8'h04, 8'h09, 8'h02, 8'h01);
        wait_done("wrap");
        tick();
        check("wrap_addr_k0", addr_log[c0 % 64], 8'hFE);
        check("wrap_addr_k1", addr_log[(c0 + 1) % 64], 8'h02);
        check("wrap_offset", o_addr_offset, 8'h03);

        // Start while busy is ignored
        c0 = n_clear; r0 = n_reuse;
        start_run(8'h20, 8'h03, 8'h09, 8'h01, 8'h02);
        repeat (4) tick();
        i_base_addr = 8'h80; i_route_size = 8'h05; i_kernel_words = 8'h07; i_num_kernels = 8'h05;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("busy_start_addr", o_start_addr, 8'h20);
        check("busy_start_rsize", o_route_size, 8'h09);
        check("busy_start_offset", o_addr_offset, 8'h02);
        wait_done("busy");
        tick();
        check("busy_clears", n_clear - c0, 1);
        check("busy_reuses", n_reuse - r0, 1);

        // Abort together with route_done
        d0 = n_done;
        start_run(8'h10, 8'h02, 8'h09, 8'h01, 8'h02);
        for (int i = 0; i < 100 && !o_data_out_en; i++) tick();
        check("simul_stream_seen", o_data_out_en, 1);
        i_abort = 1'b1; done_force = 1'b1;
        tick();
        i_abort = 1'b0; done_force = 1'b0;
        check("simul_abort", {o_reg_clear, o_route_reuse, o_pass_idx}, {1'b1, 1'b0, 8'd0});
        tick();
        check("simul_idle", o_busy, 0);
        check("simul_no_done", n_done - d0, 0);

        // Asynchronous reset mid-run
        start_run(8'h10, 8'h02, 8'h09, 8'h02, 8'h03);
        repeat (5) tick();
        #2 i_nrst = 1'b0;
        #1;
        check("areset_ctrl", {o_busy, o_reg_clear, o_route_en, o_data_out_en, o_route_reuse, o_done}, 0);
        check("areset_regs", {o_start_addr, o_route_size, o_kernel_idx, o_pass_idx}, 0);
        tick();
        i_nrst = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
